// File: rtl/npu_mac_array.sv
// rtl/npu_mac_array.sv - Pipelined signed MAC array with group accumulation and requantisation
//
// Five register stages: products, per-channel tap sum, group accumulator (IDLE/ACCUM FSM),
// round-half-up arithmetic shift, saturation to DATA_W.
// Optional build macro: NPU_MAC_ARRAY_RELU_EN clamps negative outputs to 0 after saturation.
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   in_data    IN_NUM activations, tap q at [q*DATA_W +: DATA_W], shared by all channels
//   in_weight  OUT_NUM*IN_NUM weights, (p,q) at [(p*IN_NUM+q)*WEIGHT_W +: WEIGHT_W]
//   in_bias    per-channel bias, used from the first beat of a group
//   in_valid   beat qualifier; no backpressure
//   in_last    final beat of an accumulation group
//   in_shift   requantisation right shift, used from the last beat of a group
//   out_data   per-channel results, channel p at [p*DATA_W +: DATA_W]
//   out_valid  one-cycle result strobe
//   busy       group open or any stage holding valid data
module npu_mac_array #(
    parameter int IN_NUM   = 9,
    parameter int OUT_NUM  = 18,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int BIAS_W   = 16,
    parameter int ACC_W    = 32,
    parameter int SHIFT_W  = 5
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [IN_NUM*DATA_W-1:0]             in_data,
    input  logic [OUT_NUM*IN_NUM*WEIGHT_W-1:0]   in_weight,
    input  logic [OUT_NUM*BIAS_W-1:0]            in_bias,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    input  logic [SHIFT_W-1:0]                   in_shift,
    output logic [OUT_NUM*DATA_W-1:0]            out_data,
    output logic                                 out_valid,
    output logic                                 busy
);

    localparam int PROD_W = DATA_W + WEIGHT_W;
    // One extra bit so adding the rounding constant can never overflow
    localparam int RND_W  = ACC_W + 1;
    localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [RND_W-1:0] SAT_MIN = -SAT_MAX - RND_W'(1);

    typedef enum logic [0:0] {IDLE, ACCUM} state_t;

    // Stage 1: products, plus the side-band values that travel with each beat
    logic signed [PROD_W-1:0]  s1_prod [OUT_NUM][IN_NUM];
    logic                      s1_valid;
    logic                      s1_last;
    logic [OUT_NUM*BIAS_W-1:0] s1_bias;
    logic [SHIFT_W-1:0]        s1_shift;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_bias  <= '0;
            s1_shift <= '0;
            for (int p = 0; p < OUT_NUM; p++)
                for (int q = 0; q < IN_NUM; q++)
                    s1_prod[p][q] <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_last  <= in_last;
                s1_bias  <= in_bias;
                s1_shift <= in_shift;
                for (int p = 0; p < OUT_NUM; p++)
                    for (int q = 0; q < IN_NUM; q++)
                        s1_prod[p][q] <= PROD_W'(
                            $signed(in_data[q*DATA_W +: DATA_W]) *
                            $signed(in_weight[(p*IN_NUM+q)*WEIGHT_W +: WEIGHT_W]));
            end
        end
    end

    // Stage 2: per-channel tap sum
    logic signed [ACC_W-1:0]   sum_c  [OUT_NUM];
    logic signed [ACC_W-1:0]   s2_sum [OUT_NUM];
    logic                      s2_valid;
    logic                      s2_last;
    logic [OUT_NUM*BIAS_W-1:0] s2_bias;
    logic [SHIFT_W-1:0]        s2_shift;

    always_comb begin
        for (int p = 0; p < OUT_NUM; p++) begin
            sum_c[p] = '0;
            for (int q = 0; q < IN_NUM; q++)
                sum_c[p] = sum_c[p] + ACC_W'(s1_prod[p][q]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_bias  <= '0;
            s2_shift <= '0;
            for (int p = 0; p < OUT_NUM; p++)
                s2_sum[p] <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last  <= s1_last;
                s2_bias  <= s1_bias;
                s2_shift <= s1_shift;
                for (int p = 0; p < OUT_NUM; p++)
                    s2_sum[p] <= sum_c[p];
            end
        end
    end

    // Stage 3: group accumulator; wraps modulo 2^ACC_W
    state_t                  state, state_next;
    logic signed [ACC_W-1:0] acc      [OUT_NUM];
    logic signed [ACC_W-1:0] acc_next [OUT_NUM];
    logic                    s3_valid;
    logic [SHIFT_W-1:0]      s3_shift;

    always_comb begin
        state_next = state;
        for (int p = 0; p < OUT_NUM; p++)
            acc_next[p] = acc[p];
        if (s2_valid) begin
            for (int p = 0; p < OUT_NUM; p++) begin
                if (state == IDLE)
                    acc_next[p] = ACC_W'($signed(s2_bias[p*BIAS_W +: BIAS_W])) + s2_sum[p];
                else
                    acc_next[p] = acc[p] + s2_sum[p];
            end
            state_next = s2_last ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            s3_valid <= 1'b0;
            s3_shift <= '0;
            for (int p = 0; p < OUT_NUM; p++)
                acc[p] <= '0;
        end else begin
            state    <= state_next;
            s3_valid <= s2_valid & s2_last;
            if (s2_valid & s2_last)
                s3_shift <= s2_shift;
            for (int p = 0; p < OUT_NUM; p++)
                acc[p] <= acc_next[p];
        end
    end

    // Stage 4: (acc + 2^(shift-1)) >>> shift, floor of a half-up rounded quotient
    logic signed [RND_W-1:0] rnd_c  [OUT_NUM];
    logic signed [RND_W-1:0] s4_res [OUT_NUM];
    logic signed [RND_W-1:0] one_w;
    logic signed [RND_W-1:0] half;
    logic signed [RND_W-1:0] ext;
    logic                    s4_valid;

    always_comb begin
        one_w = RND_W'(1);
        half  = '0;
        if (s3_shift != '0)
            half = one_w <<< (s3_shift - SHIFT_W'(1));
        for (int p = 0; p < OUT_NUM; p++) begin
            ext      = {acc[p][ACC_W-1], acc[p]};
            rnd_c[p] = (ext + half) >>> s3_shift;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s4_valid <= 1'b0;
            for (int p = 0; p < OUT_NUM; p++)
                s4_res[p] <= '0;
        end else begin
            s4_valid <= s3_valid;
            if (s3_valid)
                for (int p = 0; p < OUT_NUM; p++)
                    s4_res[p] <= rnd_c[p];
        end
    end

    // Stage 5: saturate (and optionally rectify), then hold until the next result
    logic [OUT_NUM*DATA_W-1:0] sat_c;

    always_comb begin
        sat_c = '0;
        for (int p = 0; p < OUT_NUM; p++) begin
            if (s4_res[p] > SAT_MAX)
                sat_c[p*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
            else if (s4_res[p] < SAT_MIN)
                sat_c[p*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
            else
                sat_c[p*DATA_W +: DATA_W] = s4_res[p][DATA_W-1:0];
`ifdef NPU_MAC_ARRAY_RELU_EN
            if (sat_c[p*DATA_W + DATA_W - 1])
                sat_c[p*DATA_W +: DATA_W] = '0;
`else
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= s4_valid;
            if (s4_valid)
                out_data <= sat_c;
        end
    end

    assign busy = s1_valid | s2_valid | (state == ACCUM) | s3_valid | s4_valid | out_valid;

endmodule

// File: tb/tb_npu_mac_array.sv
// tb/tb_npu_mac_array.sv - Directed self-checking bench for npu_mac_array
module tb_npu_mac_array;

    localparam int IN_NUM   = 9;
    localparam int OUT_NUM  = 18;
    localparam int DATA_W   = 8;
    localparam int WEIGHT_W = 8;
    localparam int BIAS_W   = 16;
    localparam int ACC_W    = 32;
    localparam int SHIFT_W  = 5;

    logic                               clk = 1'b0;
    logic                               rstn;
    logic [IN_NUM*DATA_W-1:0]           in_data;
    logic [OUT_NUM*IN_NUM*WEIGHT_W-1:0] in_weight;
    logic [OUT_NUM*BIAS_W-1:0]          in_bias;
    logic                               in_valid;
    logic                               in_last;
    logic [SHIFT_W-1:0]                 in_shift;
    logic [OUT_NUM*DATA_W-1:0]          out_data;
    logic                               out_valid;
    logic                               busy;

    npu_mac_array #(
        .IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W),
        .BIAS_W(BIAS_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)
    ) dut (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_weight(in_weight),
        .in_bias(in_bias), .in_valid(in_valid), .in_last(in_last), .in_shift(in_shift),
        .out_data(out_data), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int exp_ch [OUT_NUM];

    typedef struct {
        string name;
        int    d;
        int    w;
        int    b;
        int    sh;
        int    expv;
    } vec_t;

    vec_t vecs [8];

    function automatic int relu(input int v);
`ifdef NPU_MAC_ARRAY_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    function automatic int chan(input int p);
        logic signed [DATA_W-1:0] v;
        v = out_data[p*DATA_W +: DATA_W];
        return int'(v);
    endfunction

    task automatic check_chan(input string name);
        int bad;
        bad = -1;
        for (int p = 0; p < OUT_NUM; p++)
            if (bad < 0 && chan(p) != exp_ch[p]) bad = p;
        checks++;
        if (bad < 0) passes++;
        else $display("FAIL %s: channel %0d got %0d expected %0d", name, bad, chan(bad), exp_ch[bad]);
    endtask

    task automatic set_uniform(input int d, input int w, input int b, input int sh, input bit last);
        for (int q = 0; q < IN_NUM; q++)
            in_data[q*DATA_W +: DATA_W] = DATA_W'(d);
        for (int i = 0; i < OUT_NUM*IN_NUM; i++)
            in_weight[i*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(w);
        for (int p = 0; p < OUT_NUM; p++)
            in_bias[p*BIAS_W +: BIAS_W] = BIAS_W'(b);
        in_shift = SHIFT_W'(sh);
        in_last  = last;
        in_valid = 1'b1;
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called at the negedge right after the edge that sampled the last beat;
    // returns the number of further rising edges until out_valid is seen, or -1.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            if (out_valid) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int seen;

        vecs[0] = '{"ones",      1,    1,    0,   0,    9};
        vecs[1] = '{"sat_pos",   127,  127,  0,   0,    127};
        vecs[2] = '{"sat_neg",   127,  -128, 0,   0,    -128};
        vecs[3] = '{"rnd_m6",    0,    5,    -6,  2,    -1};
        vecs[4] = '{"rnd_p6",    0,    5,    6,   2,    2};
        vecs[5] = '{"rnd_m7",    0,    5,    -7,  2,    -2};
        vecs[6] = '{"rnd_m35",   5,    -3,   100, 3,    -4};
        vecs[7] = '{"rnd_m1072", -2,   4,    -1000, 4,  -67};

        rstn = 1'b0;
        in_data = '0; in_weight = '0; in_bias = '0; in_shift = '0;
        go_idle();
        repeat (3) @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_out_data", (out_data == '0) ? 1 : 0, 1);
        rstn = 1'b1;
        @(negedge clk);

        // Single-beat groups from the table
        for (int i = 0; i < 8; i++) begin
            set_uniform(vecs[i].d, vecs[i].w, vecs[i].b, vecs[i].sh, 1'b1);
            @(negedge clk);
            go_idle();
            check({vecs[i].name, "_busy"}, int'(busy), 1);
            wait_valid(lat);
            check({vecs[i].name, "_latency"}, lat, 4);
            for (int p = 0; p < OUT_NUM; p++) exp_ch[p] = relu(vecs[i].expv);
            check_chan(vecs[i].name);
            @(negedge clk);
            check({vecs[i].name, "_pulse"}, int'(out_valid), 0);
            check_chan({vecs[i].name, "_hold"});
            @(negedge clk);
            check({vecs[i].name, "_idle_busy"}, int'(busy), 0);
        end

        // Distinct taps, weights and biases per channel
        for (int q = 0; q < IN_NUM; q++) in_data[q*DATA_W +: DATA_W] = DATA_W'(q + 1);
        for (int p = 0; p < OUT_NUM; p++) begin
            for (int q = 0; q < IN_NUM; q++)
                in_weight[(p*IN_NUM+q)*WEIGHT_W +: WEIGHT_W] =
                    (q == p % IN_NUM) ? WEIGHT_W'(p / IN_NUM + 1) : '0;
            in_bias[p*BIAS_W +: BIAS_W] = BIAS_W'(p);
            exp_ch[p] = (p % IN_NUM + 1) * (p / IN_NUM + 1) + p;
        end
        in_shift = '0; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        go_idle();
        wait_valid(lat);
        check("per_chan_latency", lat, 4);
        check_chan("per_chan");
        repeat (2) @(negedge clk);

        // Three-beat group with a gap; bias from beat 1, shift from beat 3
        set_uniform(2, 3, 10, 7, 1'b0);
        @(negedge clk);
        set_uniform(2, 3, 999, 7, 1'b0);
        @(negedge clk);
        go_idle();
        repeat (3) @(negedge clk);
        check("gap_busy", int'(busy), 1);
        check("gap_no_output", int'(out_valid), 0);
        set_uniform(2, 3, 999, 2, 1'b1);
        @(negedge clk);
        go_idle();
        wait_valid(lat);
        check("multi_latency", lat, 4);
        for (int p = 0; p < OUT_NUM; p++) exp_ch[p] = 43;
        check_chan("multi_beat");
        repeat (2) @(negedge clk);

        // Reset in the middle of an open group
        set_uniform(1, 1, 0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        go_idle();
        repeat (3) @(negedge clk);
        check("open_group_busy", int'(busy), 1);
        rstn = 1'b0;
        #1;
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_valid", int'(out_valid), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        set_uniform(1, 1, 5, 0, 1'b1);
        @(negedge clk);
        go_idle();
        pulses = 0;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            if (out_valid) begin
                pulses++;
                seen = chan(0);
                for (int p = 0; p < OUT_NUM; p++) exp_ch[p] = 14;
                check_chan("post_reset_value");
            end
            @(negedge clk);
        end
        check("post_reset_pulses", pulses, 1);
        check("post_reset_ch0", seen, 14);

        // Back-to-back single-beat groups, each with its own shift
        set_uniform(0, 1, 8, 0, 1'b1);
        @(negedge clk);
        set_uniform(0, 1, 8, 1, 1'b1);
        @(negedge clk);
        set_uniform(0, 1, 8, 2, 1'b1);
        @(negedge clk);
        go_idle();
        wait_valid(lat);
        check("b2b_latency", lat, 2);
        for (int k = 0; k < 3; k++) begin
            check("b2b_valid", int'(out_valid), 1);
            for (int p = 0; p < OUT_NUM; p++) exp_ch[p] = 8 >> k;
            check_chan("b2b_value");
            @(negedge clk);
        end
        check("b2b_end", int'(out_valid), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/npu_mac_array.md
NPU_MAC_ARRAY -- requirements
Module: npu_mac_array

Interface
REQ-001 Parameter IN_NUM, default 9: input channels (taps) per output channel.
REQ-002 Parameter OUT_NUM, default 18: output channels computed in parallel.
REQ-003 Parameter DATA_W, default 8: signed activation width, input and output.
REQ-004 Parameter WEIGHT_W, default 8: signed weight width.
REQ-005 Parameter BIAS_W, default 16: signed bias width.
REQ-006 Parameter ACC_W, default 32: signed accumulator width; ACC_W SHALL be at least DATA_W+WEIGHT_W+clog2(IN_NUM).
REQ-007 Parameter SHIFT_W, default 5: requantisation shift width.
REQ-008 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-009 Port rstn, input, 1: reset, asynchronous, active-low.
REQ-010 Port in_data, input, IN_NUM*DATA_W: activations, tap q at [q*DATA_W +: DATA_W], broadcast to all output channels.
REQ-011 Port in_weight, input, OUT_NUM*IN_NUM*WEIGHT_W: weight (p,q) at [(p*IN_NUM+q)*WEIGHT_W +: WEIGHT_W].
REQ-012 Port in_bias, input, OUT_NUM*BIAS_W: per-channel bias, sampled on the first beat of a group.
REQ-013 Port in_valid, input, 1: beat qualifier for in_data, in_weight, in_bias, in_last and in_shift.
REQ-014 Port in_last, input, 1: marks the final beat of an accumulation group.
REQ-015 Port in_shift, input, SHIFT_W: arithmetic right-shift amount, sampled on the last beat.
REQ-016 Port out_data, output, OUT_NUM*DATA_W: requantised results, channel p at [p*DATA_W +: DATA_W].
REQ-017 Port out_valid, output, 1: one-cycle pulse qualifying out_data.
REQ-018 Port busy, output, 1: high while a group is open or any pipeline stage holds valid data.

Function
REQ-019 The block SHALL NOT apply backpressure; every beat with in_valid=1 SHALL be consumed, and cycles with in_valid=0 SHALL be ignored, including gaps inside a group.
REQ-020 Stage 1 SHALL register the OUT_NUM*IN_NUM signed products, each DATA_W+WEIGHT_W bits wide.
REQ-021 Stage 2 SHALL register the per-channel sum of IN_NUM products, sign-extended to ACC_W.
REQ-022 Stage 3 group FSM SHALL have states IDLE and ACCUM: in IDLE a beat loads acc = sign-extended bias + sum; in ACCUM a beat adds sum to acc; a beat with in_last SHALL go to IDLE, otherwise to ACCUM.
REQ-023 A beat with in_last in IDLE (single-beat group) SHALL load bias + sum and complete the group.
REQ-024 acc SHALL wrap modulo 2^ACC_W (two's complement), with no saturation at the accumulator.
REQ-025 Stage 4 SHALL compute (acc + 2^(shift-1)) >>> shift when shift>0, and pass acc unchanged when shift=0; rounding is half-up toward +infinity.
REQ-026 Stage 5 SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and register out_data.
REQ-027 Latency: a last beat sampled at edge k SHALL produce out_valid=1 for exactly the cycle following edge k+4 (5 register stages).
REQ-028 in_shift and in_bias SHALL be carried through the pipeline with their own beat, so back-to-back single-beat groups SHALL each use their own values.
REQ-029 out_data SHALL hold its last value while out_valid=0.

Reset
REQ-030 rstn low SHALL immediately clear all pipeline registers, acc, the FSM (to IDLE), out_data (0), out_valid (0) and busy (0).
REQ-031 A group open when reset asserts SHALL be discarded, with no out_valid produced for it.

Configuration
REQ-032 With macro NPU_MAC_ARRAY_RELU_EN defined, stage 5 SHALL clamp negative results to 0 after saturation; without it, the full signed range SHALL be output; latency is identical in both builds.

Verification (defaults, ReLU off unless stated)
REQ-033 One beat, all data=1, weights=1, bias=0, shift=0, last=1 -> every channel = 9, out_valid 1 cycle after 5th edge.
REQ-034 Three beats, data=2, weights=3, bias=10, shift=2, idle gap between beats 2 and 3 -> acc=172, out=43 all channels.
REQ-035 Saturation, data=127, weights=127 -> 127; weights=-128 -> -128; -128 with NPU_MAC_ARRAY_RELU_EN -> 0.
REQ-036 Rounding: bias=-6, data=0, shift=2 -> -1; bias=6 -> 2; bias=-7 -> -2.
REQ-037 Reset after 2 beats of a group, then a single beat (bias=5, sum=9, shift=0) -> exactly one out_valid, value 14.
REQ-038 Back-to-back single-beat groups with shift 0,1,2, acc=8 each -> outputs 8, 4, 2 on consecutive cycles.
